sparrow_mem_arbiter: RTL and testbench

- Shares the single unified memory port between the instruction-fetch requester and the data-access path (the load/store request/size/write-data stream produced for data memory).
- Issues at most one outstanding transaction, with a req/gnt address phase and an rvalid response phase.
- Data has fixed priority over fetch; a bounded-streak counter prevents fetch starvation.
- Sits between the core's fetch/LSU and the memory/bus.

---
 rtl/sparrow_mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sparrow_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparrow_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sparrow_mem_arbiter
//
// Shares one unified memory port between the instruction-fetch requester and
// the data (load/store) path. At most one transaction is in flight: a req/gnt
// address phase followed by an rvalid response phase.
//
// Data has fixed priority over fetch. A saturating streak counter counts data
// grants taken while a fetch is waiting. Once it reaches MAX_DATA_STREAK, the
// next arbitration goes to the fetch so it cannot be starved.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   instr_req_i/addr_i    fetch request (held with its address until gnt)
//   instr_gnt_o           fetch address phase accepted
//   instr_rvalid_o/rdata_o fetch response
//   data_req_i/addr_i/byte_en_i/wr_i/wr_data_i
//                         data request and payload (held until gnt)
//   data_gnt_o            data address phase accepted
//   data_rvalid_o/rdata_o data response (read data or write ack), raw data
//   mem_req_o/addr_o/byte_en_o/wr_o/wr_data_o
//                         request towards memory
//   mem_gnt_i             memory accepted the request
//   mem_rvalid_i/rdata_i  memory response (reads and writes both respond)
//
// Access size encoding on *_byte_en: 2'b00 byte, 2'b01 half-word, 2'b10 word.
// -----------------------------------------------------------------------------
module sparrow_mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4  // legal range 1..15
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic [1:0]  data_byte_en_i,
    input  logic        data_wr_i,
    input  logic [31:0] data_wr_data_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_byte_en_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] BE_WORD    = 2'b10;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing outstanding
        ST_REQ  = 2'd1,   // request presented, owner locked, waiting for gnt
        ST_WAIT = 2'd2    // granted, waiting for the response
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t     state_reg, state_next;
    owner_t     owner_reg, owner_next;
    logic [3:0] streak_reg, streak_next;

    owner_t     sel_owner;   // arbitration result, only meaningful in IDLE
    owner_t     cur_owner;   // owner driving the payload this cycle
    logic       any_req;
    logic       fetch_forced;
    logic       req_int;
    logic       instr_gnt_int;
    logic       data_gnt_int;

    // -------------------------------------------------------------------------
    // Arbitration. Data wins unless a fetch is waiting and the data streak has
    // already reached its limit.
    // -------------------------------------------------------------------------
    always_comb begin
        any_req      = instr_req_i | data_req_i;
        fetch_forced = instr_req_i & (streak_reg == STREAK_MAX);
        sel_owner    = (data_req_i && !fetch_forced) ? OWN_DATA : OWN_INSTR;

        // Outside IDLE the registered owner is locked; no re-arbitration.
        cur_owner = (state_reg == ST_IDLE) ? sel_owner : owner_reg;

        unique case (state_reg)
            ST_IDLE: req_int = any_req;
            ST_REQ:  req_int = 1'b1;
            default: req_int = 1'b0;
        endcase

        instr_gnt_int = req_int & mem_gnt_i & (cur_owner == OWN_INSTR);
        data_gnt_int  = req_int & mem_gnt_i & (cur_owner == OWN_DATA);
    end

    // -------------------------------------------------------------------------
    // Next-state, owner and streak logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        streak_next = streak_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    owner_next = sel_owner;
                    state_next = mem_gnt_i ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The streak only grows while a fetch is actually waiting behind data.
        if (data_gnt_int) begin
            if (!instr_req_i) begin
                streak_next = 4'd0;
            end else if (streak_reg != STREAK_MAX) begin
                streak_next = streak_reg + 4'd1;
            end
        end else if (instr_gnt_int) begin
            streak_next = 4'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= OWN_INSTR;
            streak_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            streak_reg <= streak_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Everything is forced low while reset is asserted, so a request
    // held by a requester during reset never leaks onto the memory port.
    // -------------------------------------------------------------------------
    always_comb begin
        mem_req_o      = 1'b0;
        mem_addr_o     = 32'd0;
        mem_byte_en_o  = 2'b00;
        mem_wr_o       = 1'b0;
        mem_wr_data_o  = 32'd0;
        instr_gnt_o    = 1'b0;
        data_gnt_o     = 1'b0;
        instr_rvalid_o = 1'b0;
        data_rvalid_o  = 1'b0;
        instr_rdata_o  = 32'd0;
        data_rdata_o   = 32'd0;

        if (!rst_i) begin
            mem_req_o = req_int;
            if (req_int) begin
                if (cur_owner == OWN_DATA) begin
                    mem_addr_o    = data_addr_i;
                    mem_byte_en_o = data_byte_en_i;
                    mem_wr_o      = data_wr_i;
                    mem_wr_data_o = data_wr_data_i;
                end else begin
                    // Fetches are always word reads.
                    mem_addr_o    = instr_addr_i;
                    mem_byte_en_o = BE_WORD;
                end
            end

            instr_gnt_o = instr_gnt_int;
            data_gnt_o  = data_gnt_int;

            // A response outside WAIT is stale or spurious and is dropped.
            instr_rvalid_o = (state_reg == ST_WAIT) & mem_rvalid_i & (owner_reg == OWN_INSTR);
            data_rvalid_o  = (state_reg == ST_WAIT) & mem_rvalid_i & (owner_reg == OWN_DATA);

            // Raw data to both requesters; rvalid qualifies it.
            instr_rdata_o = mem_rdata_i;
            data_rdata_o  = mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sparrow_mem_arbiter
//
// Self-checking bench for sparrow_mem_arbiter: a table of single-cycle
// vectors from a known state, hand-written multi-cycle sequences (contention
// order, reset in mid-transaction), then randomized traffic checked against a
// transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_sparrow_mem_arbiter;

    localparam int         MAXS    = 4;
    localparam logic [1:0] BE_BYTE = 2'b00;
    localparam logic [1:0] BE_HALF = 2'b01;
    localparam logic [1:0] BE_WORD = 2'b10;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic [1:0]  data_byte_en_i;
    logic        data_wr_i;
    logic [31:0] data_wr_data_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [1:0]  mem_byte_en_o;
    logic        mem_wr_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    sparrow_mem_arbiter #(.MAX_DATA_STREAK(MAXS)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_byte_en_i (data_byte_en_i),
        .data_wr_i      (data_wr_i),
        .data_wr_data_i (data_wr_data_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_byte_en_o  (mem_byte_en_o),
        .mem_wr_o       (mem_wr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    int total = 0;
    int bad   = 0;

    // Packed output snapshot:
    // {mem_req, mem_addr, mem_be, mem_wr, mem_wdata, igt, dgt, irv, drv, irdata, drdata}
    function automatic logic [135:0] ev(logic mreq, logic [31:0] addr, logic [1:0] be,
                                        logic wr, logic [31:0] wd, logic igt, logic dgt,
                                        logic irv, logic drv, logic [31:0] rd);
        return {mreq, addr, be, wr, wd, igt, dgt, irv, drv, rd, rd};
    endfunction

    function automatic logic [135:0] act_out();
        return {mem_req_o, mem_addr_o, mem_byte_en_o, mem_wr_o, mem_wr_data_o,
                instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o,
                instr_rdata_o, data_rdata_o};
    endfunction

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] ia, input logic dreq,
                         input logic [31:0] da, input logic [1:0] dbe, input logic dwr,
                         input logic [31:0] dwd, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        instr_req_i    = ireq;
        instr_addr_i   = ia;
        data_req_i     = dreq;
        data_addr_i    = da;
        data_byte_en_i = dbe;
        data_wr_i      = dwr;
        data_wr_data_i = dwd;
        mem_gnt_i      = gnt;
        mem_rvalid_i   = rv;
        mem_rdata_i    = rd;
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic         ireq;
        logic [31:0]  ia;
        logic         dreq;
        logic [31:0]  da;
        logic [1:0]   dbe;
        logic         dwr;
        logic [31:0]  dwd;
        logic         gnt;
        logic         rv;
        logic [31:0]  rd;
        logic [135:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic ireq, logic [31:0] ia, logic dreq,
                                logic [31:0] da, logic [1:0] dbe, logic dwr, logic [31:0] dwd,
                                logic gnt, logic rv, logic [31:0] rd, logic [135:0] e);
        vec_t v;
        v.name = nm; v.ireq = ireq; v.ia = ia; v.dreq = dreq; v.da = da; v.dbe = dbe;
        v.dwr = dwr; v.dwd = dwd; v.gnt = gnt; v.rv = rv; v.rd = rd; v.exp = e;
        return v;
    endfunction

    // Reference model state (transaction level)
    int   m_busy, m_pend, m_own, m_run;   // m_own: 0 fetch, 1 data
    logic i_on, d_on, d_wr;
    logic [31:0] i_addr, d_addr, d_wd;
    logic [1:0]  d_be;

    initial begin
        string order;
        logic  last_gnt;
        int    ngnt;
        int    txn;

        do_reset();

        // Each row is one cycle starting from reset (IDLE, streak 0).
        tbl.push_back(mk("reset_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,
                         ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("spurious",     0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h1111,
                         ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1111)));
        tbl.push_back(mk("fetch_c0",     1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h0,
                         ev(1, 32'h100, BE_WORD, 0, 0, 1, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("fetch_c1",     0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,
                         ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("fetch_rsp",    0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                         ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF)));
        tbl.push_back(mk("idle_after",   0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,
                         ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("wr_present",   0, 0, 1, 32'h2002, BE_HALF, 1, 32'hABCD, 0, 0, 32'h0,
                         ev(1, 32'h2002, BE_HALF, 1, 32'hABCD, 0, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("wr_gnt",       0, 0, 1, 32'h2002, BE_HALF, 1, 32'hABCD, 1, 0, 32'h0,
                         ev(1, 32'h2002, BE_HALF, 1, 32'hABCD, 0, 1, 0, 0, 32'h0)));
        tbl.push_back(mk("wr_ack",       0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,
                         ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0)));
        tbl.push_back(mk("spurious2",    0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h2222,
                         ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2222)));
        tbl.push_back(mk("lock_c0",      1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 32'h0,
                         ev(1, 32'h300, BE_WORD, 0, 0, 0, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("lock_c1",      1, 32'h300, 1, 32'h400, BE_BYTE, 0, 32'h9, 0, 0, 32'h0,
                         ev(1, 32'h300, BE_WORD, 0, 0, 0, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("lock_c2",      1, 32'h300, 1, 32'h400, BE_BYTE, 0, 32'h9, 0, 0, 32'h0,
                         ev(1, 32'h300, BE_WORD, 0, 0, 0, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("lock_c3_gnt",  1, 32'h300, 1, 32'h400, BE_BYTE, 0, 32'h9, 1, 0, 32'h0,
                         ev(1, 32'h300, BE_WORD, 0, 0, 1, 0, 0, 0, 32'h0)));
        tbl.push_back(mk("lock_rsp",     0, 0, 1, 32'h400, BE_BYTE, 0, 32'h9, 1, 1, 32'h1234,
                         ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h1234)));
        tbl.push_back(mk("data_next",    0, 0, 1, 32'h400, BE_BYTE, 0, 32'h9, 1, 0, 32'h0,
                         ev(1, 32'h400, BE_BYTE, 0, 32'h9, 0, 1, 0, 0, 32'h0)));
        tbl.push_back(mk("data_rsp",     0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55,
                         ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55)));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].ireq, tbl[i].ia, tbl[i].dreq, tbl[i].da, tbl[i].dbe,
                  tbl[i].dwr, tbl[i].dwd, tbl[i].gnt, tbl[i].rv, tbl[i].rd);
            @(negedge clk);
            chk(tbl[i].name, act_out(), tbl[i].exp);
            tick();
        end

        // ---- Reset while waiting for a response ----
        drive(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("rst_pre_gnt", act_out(), ev(1, 32'h500, BE_WORD, 0, 0, 1, 0, 0, 0, 32'h0));
        tick();
        drive(1, 32'h504, 1, 32'h600, BE_WORD, 1, 32'hF00D, 1, 0, 32'h0);
        rst_i = 1'b1;
        #1;
        chk("rst_async", act_out(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tick();
        @(negedge clk);
        chk("rst_held", act_out(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
        tick();
        rst_i = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        @(negedge clk);
        chk("rst_stale_rv", act_out(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77));
        tick();
        drive(0, 0, 1, 32'h600, BE_BYTE, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        chk("post_rst_gnt", act_out(), ev(1, 32'h600, BE_BYTE, 0, 0, 0, 1, 0, 0, 32'h0));
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
        @(negedge clk);
        chk("post_rst_rsp", act_out(), ev(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99));
        tick();

        // ---- Contention: both requesters held, immediate grant, 1-cycle response ----
        do_reset();
        order    = "";
        last_gnt = 1'b0;
        ngnt     = 0;
        for (int c = 0; c < 60 && ngnt < 10; c++) begin
            drive(1, 32'h1000, 1, 32'h2000, BE_WORD, 0, 0, 1, last_gnt, 32'h0);
            @(negedge clk);
            last_gnt = instr_gnt_o | data_gnt_o;
            if (instr_gnt_o && data_gnt_o) begin
                order = {order, "!"};
                ngnt++;
            end else if (instr_gnt_o) begin
                order = {order, "I"};
                ngnt++;
            end else if (data_gnt_o) begin
                order = {order, "D"};
                ngnt++;
            end
            tick();
        end
        total++;
        if (order != "DDDDIDDDDI") begin
            bad++;
            $display("FAIL contention_order: got %s required DDDDIDDDDI", order);
        end else begin
            $display("ok   contention_order: %s", order);
        end

        // ---- Randomized traffic against the reference model ----
        do_reset();
        m_busy = 0; m_pend = 0; m_own = 0; m_run = 0;
        i_on = 0; d_on = 0; i_addr = 0; d_addr = 0; d_be = 0; d_wr = 0; d_wd = 0;
        txn = 0;
        for (int c = 0; c < 2000; c++) begin
            logic        g, rv, present, grant, irv, drv;
            logic [31:0] rd;
            int          who;
            logic [135:0] e;

            if (!i_on && ($urandom_range(0, 99) < 50)) begin
                i_on = 1; i_addr = {$urandom} & 32'hFFFF_FFFC;
            end
            if (!d_on && ($urandom_range(0, 99) < 50)) begin
                d_on = 1; d_addr = $urandom; d_be = 2'($urandom_range(0, 2));
                d_wr = 1'($urandom_range(0, 1)); d_wd = $urandom;
            end
            g  = ($urandom_range(0, 99) < 50);
            rv = ($urandom_range(0, 99) < 40);
            rd = $urandom;
            drive(i_on, i_addr, d_on, d_addr, d_be, d_wr, d_wd, g, rv, rd);

            // Who may use the port this cycle
            who = 0;
            if (m_busy != 0) begin
                present = 0;
            end else if (m_pend != 0) begin
                present = 1; who = m_own;
            end else begin
                present = i_on | d_on;
                who = (d_on && !(i_on && m_run >= MAXS)) ? 1 : 0;
            end
            grant = present & g;
            irv = (m_busy != 0) && rv && (m_own == 0);
            drv = (m_busy != 0) && rv && (m_own == 1);
            if (!present)
                e = ev(0, 0, 0, 0, 0, 0, 0, irv, drv, rd);
            else if (who == 1)
                e = ev(1, d_addr, d_be, d_wr, d_wd, 0, grant, irv, drv, rd);
            else
                e = ev(1, i_addr, BE_WORD, 0, 0, grant, 0, irv, drv, rd);

            @(negedge clk);
            total++;
            if (act_out() !== e) begin
                bad++;
                $display("FAIL rand_cycle %0d: got %h required %h", c, act_out(), e);
            end

            // Advance the model
            if (m_busy != 0 && rv) m_busy = 0;
            if (grant) begin
                txn++;
                $display("txn %0d: %s addr=%h", txn, (who == 1) ? "data " : "fetch",
                         (who == 1) ? d_addr : i_addr);
                m_busy = 1; m_pend = 0; m_own = who;
                if (who == 1) begin
                    m_run = i_on ? ((m_run + 1 > MAXS) ? MAXS : m_run + 1) : 0;
                    d_on = 0;
                end else begin
                    m_run = 0;
                    i_on = 0;
                end
            end else if (present) begin
                m_pend = 1; m_own = who;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
